// File: rtl/lcd_pkg.sv
// lcd_pkg: constants and types shared by the LCD copy sequencer and the LCD
// controller. Holds the LCD register addresses, the controller command
// opcodes, the sequencer state encoding and the bus access kind.
package lcd_pkg;

  localparam logic [23:0] LCD_CMD_REG  = 24'h20FE;
  localparam logic [23:0] LCD_DATA_REG = 24'h20FF;

  localparam logic [7:0] SET_PAGE   = 8'hB0;
  localparam logic [7:0] SET_COL_LO = 8'h00;
  localparam logic [7:0] SET_COL_HI = 8'h10;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_REQ      = 4'd1,
    ST_CMD      = 4'd2,
    ST_CMD_GAP  = 4'd3,
    ST_RD       = 4'd4,
    ST_RD_GAP   = 4'd5,
    ST_WR       = 4'd6,
    ST_WR_GAP   = 4'd7,
    ST_PAGE_END = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_RD   = 2'd1,
    ACC_WR   = 2'd2
  } acc_kind_t;

  // Command byte sent for each step of the page/column setup sequence.
  // Every page starts at column 0, so both column nibbles are zero.
  function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [3:0] page);
    case (idx)
      2'd0:    cmd_byte = SET_PAGE | {4'd0, page};
      2'd1:    cmd_byte = SET_COL_LO;
      default: cmd_byte = SET_COL_HI;
    endcase
  endfunction

endpackage

// File: rtl/bus_access_unit.sv
// bus_access_unit: turns the sequencer's current access {kind, gap, address,
// data} into bus strobes. An access is a strobe cycle followed by a gap
// cycle; nothing is driven unless the bus is granted. Read data is captured
// at the end of a granted read gap.
//   kind, gap        access requested by the sequencer and its phase
//   address, wdata   access address / write data
//   bus_grant        bus ownership from the arbiter
//   bus_data_in      read data, valid in the gap cycle
//   bus_read/write   strobes (strobe phase only, granted only)
//   bus_address      access address while granted, else 0
//   bus_data_out     write data while granted, else 0
//   step             phase completed this cycle (granted access)
//   done             whole access completed this cycle (granted gap)
//   rdata            last captured read byte
module bus_access_unit
  import lcd_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  acc_kind_t   kind,
  input  logic        gap,
  input  logic [23:0] address,
  input  logic [7:0]  wdata,
  input  logic        bus_grant,
  input  logic [7:0]  bus_data_in,
  output logic        bus_read,
  output logic        bus_write,
  output logic [23:0] bus_address,
  output logic [7:0]  bus_data_out,
  output logic        step,
  output logic        done,
  output logic [7:0]  rdata
);

  // Grant is used combinationally so a grant loss removes the strobe in the
  // same cycle; the sequencer then rewinds to the strobe phase.
  assign step         = (kind != ACC_NONE) && bus_grant;
  assign done         = step && gap;
  assign bus_read     = step && !gap && (kind == ACC_RD);
  assign bus_write    = step && !gap && (kind == ACC_WR);
  assign bus_address  = step ? address : 24'd0;
  assign bus_data_out = (step && (kind == ACC_WR)) ? wdata : 8'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= 8'd0;
    end else if (done && (kind == ACC_RD)) begin
      rdata <= bus_data_in;
    end
  end

endmodule

// File: rtl/lcd_copy_sequencer.sv
// lcd_copy_sequencer: bus master that copies the framebuffer (PAGES pages of
// COLUMNS bytes starting at FB_BASE) into the LCD display RAM. Per page it
// requests the bus, writes the page/column setup commands, then moves every
// byte with a read followed by a data-register write, and finally releases
// the bus for one cycle.
//   clk, reset_n     clock, asynchronous active-low reset
//   start            one-cycle pulse, starts a frame copy when idle
//   bus_grant        bus ownership from the arbiter
//   bus_data_in      read data, valid the cycle after bus_read
//   bus_request      bus ownership request
//   bus_read/write   access strobes
//   bus_address      access address
//   bus_data_out     write data
//   busy             frame copy in progress
//   frame_done       pulse with the final PAGE_END cycle
module lcd_copy_sequencer
  import lcd_pkg::*;
#(
  parameter logic [23:0] FB_BASE       = 24'h1000,
  parameter int          COLUMNS       = 96,
  parameter int          PAGES         = 8,
  parameter logic [23:0] LCD_CMD_ADDR  = LCD_CMD_REG,
  parameter logic [23:0] LCD_DATA_ADDR = LCD_DATA_REG
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        bus_grant,
  input  logic [7:0]  bus_data_in,
  output logic        bus_request,
  output logic        bus_read,
  output logic        bus_write,
  output logic [23:0] bus_address,
  output logic [7:0]  bus_data_out,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [7:0]  LAST_COL  = 8'(COLUMNS - 1);
  localparam logic [3:0]  LAST_PAGE = 4'(PAGES - 1);
  localparam logic [10:0] COLS_11   = 11'(COLUMNS);

  state_t      state;
  logic [3:0]  page;
  logic [7:0]  col;
  logic [1:0]  cmd_idx;

  acc_kind_t   acc_kind;
  logic        acc_gap;
  logic [23:0] acc_address;
  logic [7:0]  acc_wdata;
  logic        step;
  logic        done;
  logic [7:0]  rdata;

  logic [10:0] page_offset;
  logic [23:0] fb_address;

  assign page_offset = {7'd0, page} * COLS_11;
  assign fb_address  = FB_BASE + {13'd0, page_offset} + {16'd0, col};

  // Current access as seen by the bus access unit.
  always_comb begin
    acc_kind    = ACC_NONE;
    acc_gap     = 1'b0;
    acc_address = 24'd0;
    acc_wdata   = 8'd0;
    case (state)
      ST_CMD, ST_CMD_GAP: begin
        acc_kind    = ACC_WR;
        acc_gap     = (state == ST_CMD_GAP);
        acc_address = LCD_CMD_ADDR;
        acc_wdata   = cmd_byte(cmd_idx, page);
      end
      ST_RD, ST_RD_GAP: begin
        acc_kind    = ACC_RD;
        acc_gap     = (state == ST_RD_GAP);
        acc_address = fb_address;
      end
      ST_WR, ST_WR_GAP: begin
        acc_kind    = ACC_WR;
        acc_gap     = (state == ST_WR_GAP);
        acc_address = LCD_DATA_ADDR;
        acc_wdata   = rdata;
      end
      default: ;
    endcase
  end

  bus_access_unit u_bus_access_unit (
    .clk          (clk),
    .reset_n      (reset_n),
    .kind         (acc_kind),
    .gap          (acc_gap),
    .address      (acc_address),
    .wdata        (acc_wdata),
    .bus_grant    (bus_grant),
    .bus_data_in  (bus_data_in),
    .bus_read     (bus_read),
    .bus_write    (bus_write),
    .bus_address  (bus_address),
    .bus_data_out (bus_data_out),
    .step         (step),
    .done         (done),
    .rdata        (rdata)
  );

  // A strobe state holds while ungranted; a gap state that loses the grant
  // falls back to its strobe state so the whole access is redone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      page    <= 4'd0;
      col     <= 8'd0;
      cmd_idx <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_REQ;
            page  <= 4'd0;
          end
        end
        ST_REQ: begin
          if (bus_grant) begin
            state   <= ST_CMD;
            cmd_idx <= 2'd0;
          end
        end
        ST_CMD: if (step) state <= ST_CMD_GAP;
        ST_CMD_GAP: begin
          if (!done) begin
            state <= ST_CMD;
          end else if (cmd_idx < 2'd2) begin
            cmd_idx <= cmd_idx + 2'd1;
            state   <= ST_CMD;
          end else begin
            col   <= 8'd0;
            state <= ST_RD;
          end
        end
        ST_RD:     if (step) state <= ST_RD_GAP;
        ST_RD_GAP: state <= done ? ST_WR : ST_RD;
        ST_WR:     if (step) state <= ST_WR_GAP;
        ST_WR_GAP: begin
          if (!done) begin
            state <= ST_WR;
          end else if (col < LAST_COL) begin
            col   <= col + 8'd1;
            state <= ST_RD;
          end else begin
            state <= ST_PAGE_END;
          end
        end
        ST_PAGE_END: begin
          if (page < LAST_PAGE) begin
            page  <= page + 4'd1;
            state <= ST_REQ;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state != ST_IDLE);
  assign bus_request = (state != ST_IDLE) && (state != ST_PAGE_END);
  assign frame_done  = (state == ST_PAGE_END) && (page >= LAST_PAGE);

endmodule

// File: tb/tb_lcd_copy_sequencer.sv
// Directed bench for lcd_copy_sequencer: a framebuffer RAM model, an LCD
// controller model decoding page/column commands, and bus protocol monitors.
module tb_lcd_copy_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        bus_grant = 1'b1;
  logic [7:0]  bus_data_in = 8'hEE;
  logic        bus_request;
  logic        bus_read;
  logic        bus_write;
  logic [23:0] bus_address;
  logic [7:0]  bus_data_out;
  logic        busy;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int fb_mode = 0;

  lcd_copy_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .bus_grant    (bus_grant),
    .bus_data_in  (bus_data_in),
    .bus_request  (bus_request),
    .bus_read     (bus_read),
    .bus_write    (bus_write),
    .bus_address  (bus_address),
    .bus_data_out (bus_data_out),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  // Framebuffer contents: mode 0 = low address byte, mode 1 = scrambled.
  function automatic logic [7:0] fb_byte(input logic [23:0] a, input int mode);
    logic [7:0] t;
    if (mode == 0) begin
      t = a[7:0];
    end else begin
      t = a[7:0] * 8'd3;
      t = t + a[15:8];
    end
    return t;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitors and bus/LCD models, all sampled on the falling edge.
  int         ovl = 0, nogrant = 0, dblwr = 0, reqgap = 0, ndone = 0, acc_n = 0;
  bit         prev_wr = 1'b0, hold = 1'b0;
  logic [3:0] lp = 4'd0;
  logic [7:0] lc = 8'd0;
  logic [7:0] lcd  [0:15][0:255];
  int         wcnt [0:15][0:255];
  bit         acc_w [0:8191];
  logic [23:0] acc_a [0:8191];
  logic [7:0]  acc_d [0:8191];

  always @(negedge clk) begin
    if (bus_read) begin
      bus_data_in = fb_byte(bus_address, fb_mode);
      hold = 1'b1;
    end else if (hold) begin
      hold = 1'b0;
    end else begin
      bus_data_in = 8'hEE;
    end
    if (bus_read && bus_write) ovl++;
    if ((bus_read || bus_write) && !bus_grant) nogrant++;
    if (bus_write && prev_wr) dblwr++;
    prev_wr = bus_write;
    if (busy && !bus_request && !frame_done) reqgap++;
    if (frame_done) ndone++;
    if (bus_read || bus_write) begin
      if (acc_n < 8192) begin
        acc_w[acc_n] = bus_write;
        acc_a[acc_n] = bus_address;
        acc_d[acc_n] = bus_data_out;
      end
      acc_n++;
    end
    if (bus_write && bus_address == 24'h20FE) begin
      if (bus_data_out[7:4] == 4'hB) lp = bus_data_out[3:0];
      else if (bus_data_out[7:4] == 4'h0) lc[3:0] = bus_data_out[3:0];
      else if (bus_data_out[7:4] == 4'h1) lc[7:4] = bus_data_out[3:0];
    end
    if (bus_write && bus_address == 24'h20FF) begin
      lcd[lp][lc] = bus_data_out;
      wcnt[lp][lc]++;
      lc = lc + 8'd1;
    end
  end

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles and frame_done pulses until busy drops (bounded).
  task automatic run_frame(input int limit, output int bcyc, output int dcnt);
    bcyc = 0;
    dcnt = 0;
    for (int i = 0; i < limit; i++) begin
      if (!busy && bcyc > 0) break;
      if (busy) bcyc++;
      if (frame_done) dcnt++;
      @(negedge clk);
    end
  endtask

  task automatic count_lcd(input int mode, output int m);
    m = 0;
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 96; c++)
        if (lcd[p][c] !== fb_byte(24'h1000 + 24'(p * 96 + c), mode)) m++;
  endtask

  function automatic int count_reads(input int lo, input int hi, input logic [23:0] a);
    int n = 0;
    for (int i = lo; i < hi && i < 8192; i++)
      if (!acc_w[i] && acc_a[i] == a) n++;
    return n;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int bc, dc, m, base, base2, base3;
  int rg0, dw0, ov0, ng0, dn0, wc0;
  bit found_rd, found_p4, found_p5;

  initial begin
    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_req", bus_request, 0);
    check_eq("rst_rd", bus_read, 0);
    check_eq("rst_wr", bus_write, 0);
    check_eq("rst_addr", bus_address, 0);
    check_eq("rst_dout", bus_data_out, 0);
    check_eq("rst_done", frame_done, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_req", bus_request, 0);

    // Frame 1: grant held high, scrambled framebuffer
    fb_mode = 1;
    base = acc_n;
    rg0 = reqgap; dw0 = dblwr; ov0 = ovl; ng0 = nogrant;
    pulse_start();
    check_eq("busy_rise", busy, 1);
    run_frame(5000, bc, dc);
    check_eq("f1_cycles", bc, 3136);
    check_eq("f1_done_cnt", dc, 1);
    check_eq("f1_busy_clr", busy, 0);
    check_eq("a0_addr", acc_a[base], 24'h20FE);
    check_eq("a0_data", acc_d[base], 8'hB0);
    check_eq("a1_addr", acc_a[base+1], 24'h20FE);
    check_eq("a1_data", acc_d[base+1], 8'h00);
    check_eq("a2_addr", acc_a[base+2], 24'h20FE);
    check_eq("a2_data", acc_d[base+2], 8'h10);
    check_eq("a3_isrd", acc_w[base+3], 0);
    check_eq("a3_addr", acc_a[base+3], 24'h1000);
    check_eq("a4_addr", acc_a[base+4], 24'h20FF);
    check_eq("a4_data", acc_d[base+4], 8'h10);
    count_lcd(1, m);
    check_eq("f1_lcd_mism", m, 0);
    check_eq("f1_req_gaps", reqgap - rg0, 7);
    check_eq("f1_dbl_wr", dblwr - dw0, 0);
    check_eq("f1_rw_ovl", ovl - ov0, 0);
    check_eq("f1_nogrant", nogrant - ng0, 0);

    // Frame 2: grant loss in RD_GAP of page 2 col 40, start while busy
    fb_mode = 0;
    base2 = acc_n;
    rg0 = reqgap; dw0 = dblwr; ng0 = nogrant;
    wc0 = wcnt[2][40];
    found_rd = 1'b0;
    found_p4 = 1'b0;
    pulse_start();
    fork
      run_frame(6000, bc, dc);
      begin
        for (int i = 0; i < 2000 && !found_rd; i++) begin
          @(negedge clk);
          if (bus_read && bus_address == 24'h10E8) found_rd = 1'b1;
        end
        check_eq("find_rd_10e8", found_rd, 1);
        if (found_rd) begin
          @(posedge clk);
          #1 bus_grant = 1'b0;
          @(negedge clk);
          check_eq("drop_req", bus_request, 1);
          check_eq("drop_rd", bus_read, 0);
          check_eq("drop_addr", bus_address, 0);
          repeat (10) @(posedge clk);
          #1 bus_grant = 1'b1;
        end
        for (int i = 0; i < 4000 && !found_p4; i++) begin
          @(negedge clk);
          if (bus_read && bus_address == 24'h1180) found_p4 = 1'b1;
        end
        check_eq("find_rd_1180", found_p4, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    check_eq("f2_cycles", bc, 3147);
    check_eq("f2_done_cnt", dc, 1);
    check_eq("f2_reads_10e8", count_reads(base2, acc_n, 24'h10E8), 2);
    check_eq("f2_wr_p2c40", wcnt[2][40] - wc0, 1);
    check_eq("f2_lcd_p2c40", lcd[2][40], 8'hE8);
    check_eq("f2_lcd_p3c5", lcd[3][5], 8'h25);
    count_lcd(0, m);
    check_eq("f2_lcd_mism", m, 0);
    check_eq("f2_nogrant", nogrant - ng0, 0);
    check_eq("f2_dbl_wr", dblwr - dw0, 0);
    check_eq("f2_req_gaps", reqgap - rg0, 7);

    // Frame 3: reset during a page 5 data write, then a full frame
    found_p5 = 1'b0;
    pulse_start();
    for (int i = 0; i < 3000 && !found_p5; i++) begin
      @(negedge clk);
      if (bus_read && bus_address == 24'h11EA) found_p5 = 1'b1;
    end
    check_eq("find_rd_11ea", found_p5, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("pre_rst_wr", bus_write, 1);
    check_eq("pre_rst_dout", bus_data_out, 8'hEA);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_req", bus_request, 0);
    check_eq("mid_rst_wr", bus_write, 0);
    check_eq("mid_rst_rd", bus_read, 0);
    check_eq("mid_rst_addr", bus_address, 0);
    check_eq("mid_rst_dout", bus_data_out, 0);
    check_eq("mid_rst_done", frame_done, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    fb_mode = 1;
    base3 = acc_n;
    dn0 = ndone;
    pulse_start();
    run_frame(5000, bc, dc);
    check_eq("f3_cycles", bc, 3136);
    check_eq("f3_done_cnt", ndone - dn0, 1);
    check_eq("f3_a0_addr", acc_a[base3], 24'h20FE);
    check_eq("f3_a0_data", acc_d[base3], 8'hB0);
    count_lcd(1, m);
    check_eq("f3_lcd_mism", m, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
